// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer.
// Next-PC selects, offset selects and temp-buffer states.
package pc_seq_pkg;

    localparam logic [2:0] SEL_HOLD = 3'd0;
    localparam logic [2:0] SEL_INC  = 3'd1;
    localparam logic [2:0] SEL_RST  = 3'd2;
    localparam logic [2:0] SEL_INT  = 3'd3;
    localparam logic [2:0] SEL_ZERO = 3'd4;
    localparam logic [2:0] SEL_ABS  = 3'd5;
    localparam logic [2:0] SEL_REL  = 3'd6;
    localparam logic [2:0] SEL_RSVD = 3'd7;

    localparam logic [1:0] OFS_PC  = 2'd0;
    localparam logic [1:0] OFS_P1  = 2'd1;
    localparam logic [1:0] OFS_P2  = 2'd2;
    localparam logic [1:0] OFS_REL = 2'd3;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_HAVE_LO = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_t;

endpackage

// File: rtl/pc_temp_buf.sv
// Two-byte operand buffer (lo first, then hi).
// A consume empties it unless a new byte arrives in the same cycle.
module pc_temp_buf
    import pc_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       write,
    input  logic       consume,
    input  logic [7:0] data,
    output logic [7:0] lo,
    output logic [7:0] hi,
    output buf_state_t state,
    output logic       overflow
);

    assign overflow = write && !consume && (state == BUF_FULL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= BUF_EMPTY;
            lo    <= 8'h00;
            hi    <= 8'h00;
        end else if (consume) begin
            if (write) begin
                lo    <= data;
                state <= BUF_HAVE_LO;
            end else begin
                state <= BUF_EMPTY;
            end
        end else if (write) begin
            case (state)
                BUF_EMPTY: begin
                    lo    <= data;
                    state <= BUF_HAVE_LO;
                end
                BUF_HAVE_LO: begin
                    hi    <= data;
                    state <= BUF_FULL;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with vector tables,
// absolute/relative jumps from a byte-wise operand buffer.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int                 ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC   = 16'h0000,
    parameter logic [ADDR_W-1:0]  RST_BASE   = 16'h0000,
    parameter logic [ADDR_W-1:0]  INT_BASE   = 16'h0040,
    parameter int                 INT_STRIDE = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_en,
    input  logic [2:0]        pc_sel,
    input  logic [2:0]        rst_pc_in,
    input  logic [2:0]        int_pc_in,
    input  logic [7:0]        data_bus,
    input  logic              write_temp_buf,
    input  logic [1:0]        offset_sel,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_w_offset,
    output logic [ADDR_W-1:0] pc_saved,
    output logic [1:0]        buf_state,
    output logic              err
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] saved_q;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] sext_lo;
    logic [ADDR_W-1:0] rst_vec;
    logic [ADDR_W-1:0] int_vec;
    logic [7:0]        lo;
    logic [7:0]        hi;
    buf_state_t        buf_st;
    logic              overflow;
    logic              consume;
    logic              save;
    logic              bad;
    logic              err_q;

    pc_temp_buf u_buf (
        .clock    (clock),
        .reset    (reset),
        .write    (write_temp_buf),
        .consume  (consume),
        .data     (data_bus),
        .lo       (lo),
        .hi       (hi),
        .state    (buf_st),
        .overflow (overflow)
    );

    assign sext_lo = {{(ADDR_W-8){lo[7]}}, lo};
    assign rst_vec = RST_BASE
                   + {{(ADDR_W-6){1'b0}}, rst_pc_in, 3'b000};
    assign int_vec = INT_BASE
                   + ADDR_W'(INT_STRIDE)
                   * {{(ADDR_W-3){1'b0}}, int_pc_in};

    always_comb begin
        next_pc = pc_q;
        save    = 1'b0;
        consume = 1'b0;
        bad     = 1'b0;
        if (pc_en) begin
            unique case (pc_sel)
                SEL_HOLD: ;
                SEL_INC:  next_pc = pc_q + ADDR_W'(1);
                SEL_RST: begin
                    next_pc = rst_vec;
                    save    = 1'b1;
                end
                SEL_INT: begin
                    next_pc = int_vec;
                    save    = 1'b1;
                end
                SEL_ZERO: begin
                    next_pc = '0;
                    save    = 1'b1;
                end
                SEL_ABS: begin
                    if (buf_st == BUF_FULL) begin
                        next_pc = ADDR_W'({hi, lo});
                        save    = 1'b1;
                        consume = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                SEL_REL: begin
                    if (buf_st != BUF_EMPTY) begin
                        next_pc = pc_q + sext_lo;
                        save    = 1'b1;
                        consume = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: bad = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            saved_q <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            pc_q  <= next_pc;
            err_q <= bad | overflow;
            if (save) begin
                saved_q <= pc_q;
            end
        end
    end

    always_comb begin
        pc_w_offset = pc_q;
        unique case (offset_sel)
            OFS_PC:  pc_w_offset = pc_q;
            OFS_P1:  pc_w_offset = pc_q + ADDR_W'(1);
            OFS_P2:  pc_w_offset = pc_q + ADDR_W'(2);
            OFS_REL: pc_w_offset = pc_q + sext_lo;
            default: pc_w_offset = pc_q;
        endcase
    end

    assign pc        = pc_q;
    assign pc_saved  = saved_q;
    assign buf_state = buf_st;
    assign err       = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq with a per-cycle reference model.
// Literal checks pin the model on the key scenarios.
module tb_pc_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pc_en = 1'b0;
    logic [2:0]  pc_sel = 3'd0;
    logic [2:0]  rst_pc_in = 3'd0;
    logic [2:0]  int_pc_in = 3'd0;
    logic [7:0]  data_bus = 8'h00;
    logic        write_temp_buf = 1'b0;
    logic [1:0]  offset_sel = 2'd0;
    logic [15:0] pc;
    logic [15:0] pc_w_offset;
    logic [15:0] pc_saved;
    logic [1:0]  buf_state;
    logic        err;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    pc_seq dut (
        .clock          (clock),
        .reset          (reset),
        .pc_en          (pc_en),
        .pc_sel         (pc_sel),
        .rst_pc_in      (rst_pc_in),
        .int_pc_in      (int_pc_in),
        .data_bus       (data_bus),
        .write_temp_buf (write_temp_buf),
        .offset_sel     (offset_sel),
        .pc             (pc),
        .pc_w_offset    (pc_w_offset),
        .pc_saved       (pc_saved),
        .buf_state      (buf_state),
        .err            (err)
    );

    always #5 clock = ~clock;

    // Reference model: byte count + last lo/hi, plain integer arithmetic
    int m_pc, m_saved, m_lo, m_hi, m_cnt;
    bit m_err;

    function automatic int rel(input int base, input int b);
        return (base + (b >= 128 ? b - 256 : b)) & 'hFFFF;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pc = 0; m_saved = 0; m_lo = 0; m_hi = 0;
            m_cnt = 0; m_err = 0;
        end else begin
            int np;
            bit took;
            bit e;
            np = m_pc; took = 0; e = 0;
            if (pc_en) begin
                case (int'(pc_sel))
                    1: np = (m_pc + 1) & 'hFFFF;
                    2: begin np = 8 * int'(rst_pc_in); m_saved = m_pc; end
                    3: begin np = 'h40 + 8 * int'(int_pc_in); m_saved = m_pc; end
                    4: begin np = 0; m_saved = m_pc; end
                    5: if (m_cnt == 2) begin
                           np = m_hi * 256 + m_lo; m_saved = m_pc; took = 1;
                       end else e = 1;
                    6: if (m_cnt >= 1) begin
                           np = rel(m_pc, m_lo); m_saved = m_pc; took = 1;
                       end else e = 1;
                    7: e = 1;
                    default: ;
                endcase
            end
            if (took) begin
                if (write_temp_buf) begin m_lo = int'(data_bus); m_cnt = 1; end
                else m_cnt = 0;
            end else if (write_temp_buf) begin
                if (m_cnt == 2) e = 1;
                else if (m_cnt == 0) begin m_lo = int'(data_bus); m_cnt = 1; end
                else begin m_hi = int'(data_bus); m_cnt = 2; end
            end
            m_pc = np;
            m_err = e;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            int eo;
            case (int'(offset_sel))
                0: eo = m_pc;
                1: eo = (m_pc + 1) & 'hFFFF;
                2: eo = (m_pc + 2) & 'hFFFF;
                default: eo = rel(m_pc, m_lo);
            endcase
            check("model_pc", int'(pc), m_pc);
            check("model_saved", int'(pc_saved), m_saved);
            check("model_buf", int'(buf_state), m_cnt);
            check("model_err", int'(err), int'(m_err));
            check("model_ofs", int'(pc_w_offset), eo);
        end
    end

    task automatic step(input logic en, input logic [2:0] sel,
                        input logic w, input logic [7:0] d);
        pc_en = en; pc_sel = sel; write_temp_buf = w; data_bus = d;
        @(posedge clock);
        #1;
        pc_en = 1'b0; pc_sel = 3'd0; write_temp_buf = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", int'(pc), 'h0000);
        check("rst_saved", int'(pc_saved), 'h0000);
        check("rst_buf", int'(buf_state), 0);
        check("rst_err", int'(err), 0);
        reset = 1'b1;
        chk_en = 1'b1;

        repeat (3) step(1, 3'd1, 0, 8'h00);
        check("inc3_pc", int'(pc), 'h0003);
        check("inc3_saved", int'(pc_saved), 'h0000);

        step(0, 3'd0, 1, 8'h34);
        step(0, 3'd0, 1, 8'h12);
        check("full_buf", int'(buf_state), 2);
        step(1, 3'd5, 0, 8'h00);
        check("abs_pc", int'(pc), 'h1234);
        check("abs_buf", int'(buf_state), 0);
        check("abs_saved", int'(pc_saved), 'h0003);

        step(0, 3'd0, 1, 8'h00);
        step(0, 3'd0, 1, 8'h01);
        step(1, 3'd5, 0, 8'h00);
        check("pc_0100", int'(pc), 'h0100);
        step(0, 3'd0, 1, 8'hFE);
        offset_sel = 2'd3;
        #1;
        check("ofs_rel", int'(pc_w_offset), 'h00FE);
        step(1, 3'd6, 0, 8'h00);
        check("rel_neg", int'(pc), 'h00FE);
        offset_sel = 2'd2;

        step(0, 3'd0, 1, 8'hFF);
        step(0, 3'd0, 1, 8'hFF);
        step(1, 3'd5, 0, 8'h00);
        step(1, 3'd1, 0, 8'h00);
        check("wrap_pc", int'(pc), 'h0000);
        check("wrap_saved", int'(pc_saved), 'h00FE);

        int_pc_in = 3'd2;
        step(1, 3'd3, 0, 8'h00);
        check("int_vec", int'(pc), 'h0050);
        rst_pc_in = 3'd7;
        step(1, 3'd2, 0, 8'h00);
        check("rst_vec", int'(pc), 'h0038);
        check("rst_vec_saved", int'(pc_saved), 'h0050);

        step(0, 3'd0, 1, 8'h80);
        step(1, 3'd6, 0, 8'h00);
        check("rel_m128", int'(pc), 'hFFB8);
        offset_sel = 2'd1;

        step(0, 3'd0, 1, 8'hAA);
        step(0, 3'd0, 1, 8'hBB);
        step(0, 3'd0, 1, 8'hCC);
        check("ovf_err", int'(err), 1);
        check("ovf_buf", int'(buf_state), 2);
        step(0, 3'd0, 0, 8'h00);
        check("ovf_err_clr", int'(err), 0);
        step(1, 3'd5, 0, 8'h00);
        check("ovf_kept", int'(pc), 'hBBAA);

        step(0, 3'd0, 1, 8'h11);
        step(1, 3'd5, 0, 8'h00);
        check("abs_lo_hold", int'(pc), 'hBBAA);
        check("abs_lo_err", int'(err), 1);
        offset_sel = 2'd3;
        step(1, 3'd6, 1, 8'h22);
        check("rel_wr_pc", int'(pc), 'hBBBB);
        check("rel_wr_buf", int'(buf_state), 1);
        check("rel_wr_ofs", int'(pc_w_offset), 'hBBDD);

        step(1, 3'd7, 0, 8'h00);
        check("rsvd_err", int'(err), 1);
        check("rsvd_pc", int'(pc), 'hBBBB);
        step(0, 3'd4, 0, 8'h00);
        check("dis_pc", int'(pc), 'hBBBB);
        step(1, 3'd4, 0, 8'h00);
        check("zero_pc", int'(pc), 'h0000);
        check("zero_saved", int'(pc_saved), 'hBBBB);

        step(1, 3'd1, 0, 8'h00);
        step(0, 3'd0, 1, 8'h55);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_pc", int'(pc), 'h0000);
        check("mid_rst_buf", int'(buf_state), 0);
        check("mid_rst_ofs", int'(pc_w_offset), 'h0000);
        @(negedge clock);
        #1;
        reset = 1'b1;
        step(1, 3'd1, 0, 8'h00);
        check("post_rst_pc", int'(pc), 'h0001);
        check("post_rst_buf", int'(buf_state), 0);
        step(0, 3'd0, 1, 8'h66);
        step(1, 3'd6, 0, 8'h00);
        check("post_rst_rel", int'(pc), 'h0067);

        step(0, 3'd0, 0, 8'h00);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: width of the PC and of every address output.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-003 SHALL have parameter RST_BASE, default 16'h0000: base address of the RST vector table, stride 8.
REQ-004 SHALL have parameters INT_BASE, default 16'h0040, and INT_STRIDE, default 8: interrupt vector base and spacing.
REQ-005 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pc_en, input, 1: pc_sel takes effect only when high.
REQ-008 SHALL have port pc_sel, input, 3: next-PC source (encodings in REQ-016).
REQ-009 SHALL have port rst_pc_in, input, 3: RST vector index 0-7.
REQ-010 SHALL have port int_pc_in, input, 3: interrupt vector index 0-7.
REQ-011 SHALL have ports data_bus, input, 8, and write_temp_buf, input, 1: operand byte and its capture strobe.
REQ-012 SHALL have port offset_sel, input, 2: selects the pc_w_offset term.
REQ-013 SHALL have ports pc, output, ADDR_W, and pc_w_offset, output, ADDR_W.
REQ-014 SHALL have port pc_saved, output, ADDR_W: PC value immediately before the last non-sequential update.
REQ-015 SHALL have ports buf_state, output, 2 (0 EMPTY, 1 HAVE_LO, 2 FULL) and err, output, 1: single-cycle error pulse.

Function
REQ-016 SHALL decode pc_sel as: 0 hold; 1 pc+1; 2 RST_BASE+8*rst_pc_in; 3 INT_BASE+INT_STRIDE*int_pc_in; 4 zero; 5 {hi,lo} from temp buffer; 6 pc+sext(lo); 7 reserved (hold, err=1).
REQ-017 SHALL register every PC update on the rising clock edge, so the new value is visible one cycle after the select.
REQ-018 SHALL hold pc when pc_en=0, whatever pc_sel is.
REQ-019 SHALL compute all arithmetic modulo 2^ADDR_W; pc=all-ones with sel 1 gives 0; sel 6 with lo=8'h80 gives pc-128.
REQ-020 SHALL implement the temp buffer as an FSM: EMPTY->HAVE_LO on write (captures lo); HAVE_LO->FULL on write (captures hi).
REQ-021 SHALL ignore write_temp_buf while FULL, pulse err, and keep buffer contents unchanged.
REQ-022 SHALL, for sel 5, require buf_state FULL; otherwise hold pc and pulse err.
REQ-023 SHALL, for sel 6, require buf_state not EMPTY; otherwise hold pc and pulse err.
REQ-024 SHALL return the buffer to EMPTY after a successful sel 5/6 consume.
REQ-025 SHALL, when write_temp_buf coincides with a consume, use the old contents for the PC and capture the new byte as lo (next state HAVE_LO).
REQ-026 SHALL update pc_saved to the old pc on every successful update with sel 2, 3, 4, 5 or 6, and leave it unchanged for sel 0, 1, 7.
REQ-027 SHALL drive pc_w_offset combinationally from current pc: 0 pc; 1 pc+1; 2 pc+2; 3 pc+sext(lo), computed with the current lo regardless of buf_state.
REQ-028 SHALL raise err for exactly one cycle per offending cycle and never latch it.

Reset
REQ-029 SHALL on reset low asynchronously set pc=RESET_PC, pc_saved=RESET_PC, buffer EMPTY, lo=hi=0, err=0.
REQ-030 SHALL abandon a partly filled buffer when reset arrives mid-operation, with no residual byte after release.
REQ-031 SHALL take its first update on the first rising edge after reset deasserts.

Structure
REQ-032 SHALL define the pc_sel and offset_sel encodings and the buffer-state enum in shared package pc_seq_pkg.
REQ-033 SHALL place the temp-buffer FSM and byte registers in sub-module pc_temp_buf (ports: write, consume, lo, hi, state, overflow).

Verification
REQ-034 SHALL cover: reset, then sel=1 with pc_en=1 for 3 cycles -> pc=0x0003, pc_saved=0x0000.
REQ-035 SHALL cover: writes 0x34 then 0x12, then sel=5 -> pc=0x1234, buf_state EMPTY, pc_saved=previous pc.
REQ-036 SHALL cover: pc=0x0100, write 0xFE, sel=6 -> pc=0x00FE; pc=0xFFFF, sel=1 -> pc=0x0000.
REQ-037 SHALL cover: sel=3 with int_pc_in=2 -> pc=0x0050; sel=2 with rst_pc_in=7 -> pc=0x0038.
REQ-038 SHALL cover: third write while FULL -> err pulse, contents kept; sel=5 while HAVE_LO -> pc held, err pulse.
REQ-039 SHALL cover: reset asserted between lo and hi writes -> buf_state EMPTY, pc=RESET_PC immediately.
